// File: rtl/sd_otf_converter.sv
// On-the-fly converter: assembles an MSD-first radix-2 signed-digit stream into a
// two's-complement word using shift-and-select Q/QM registers, one word per frame.
module sd_otf_converter #(
  parameter int N_DIGITS = 16,
  parameter int DISCARD  = 0,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic [1:0]          p_value,
  input  logic                data_in_vld,
  output logic                data_in_rdy,
  output logic [N_DIGITS:0]   dout,
  output logic                dout_err,
  output logic                data_out_vld,
  input  logic                data_out_rdy
);

  localparam int W = N_DIGITS + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS + DISCARD - 1);
  localparam logic [W-1:0]     Q_INIT   = {W{1'b0}};
  localparam logic [W-1:0]     QM_INIT  = {W{1'b1}};

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

  generate
    if ((64'd1 << CNT_W) <= 64'(N_DIGITS + DISCARD)) begin : g_cnt_w_chk
      $fatal(1, "CNT_W too narrow for N_DIGITS+DISCARD");
    end
  endgenerate

  // One conversion step: returns {Q_next, QM_next}; code 11 behaves as a zero digit.
  function automatic logic [2*W-1:0] otf_next(input logic [W-1:0] q,
                                               input logic [W-1:0] qm,
                                               input logic [1:0]   code);
    logic [W-1:0] nq;
    logic [W-1:0] nqm;
    case (code)
      2'b10: begin
        nq  = {q[W-2:0], 1'b1};
        nqm = {q[W-2:0], 1'b0};
      end
      2'b01: begin
        nq  = {qm[W-2:0], 1'b1};
        nqm = {qm[W-2:0], 1'b0};
      end
      default: begin
        nq  = {q[W-2:0], 1'b0};
        nqm = {qm[W-2:0], 1'b1};
      end
    endcase
    return {nq, nqm};
  endfunction

  state_t           state_q, state_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     qm_q, qm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_rdy_q, in_rdy_d;
  logic             out_vld_q, out_vld_d;
  logic             accept_s;
  logic             take_s;
  logic             in_discard_s;

  assign accept_s = in_rdy_q & data_in_vld;
  assign take_s   = out_vld_q & data_out_rdy;

  generate
    if (DISCARD > 0) begin : g_discard
      assign in_discard_s = (cnt_q < CNT_W'(DISCARD));
    end else begin : g_no_discard
      assign in_discard_s = 1'b0;
    end
  endgenerate

  // Next-state decode for the collect/done frame sequencer and the Q/QM datapath.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (p_value == 2'b11) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (!in_discard_s) begin
            {q_d, qm_d} = otf_next(q_q, qm_q, p_value);
          end else begin
            q_d  = q_q;
            qm_d = qm_q;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: begin
        if (take_s) begin
          q_d     = Q_INIT;
          qm_d    = QM_INIT;
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b0;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        q_d     = Q_INIT;
        qm_d    = QM_INIT;
        cnt_d   = {CNT_W{1'b0}};
        err_d   = 1'b0;
        state_d = ST_COLLECT;
      end
    endcase
    // Handshake flags are registered copies of the next state, so rdy never depends on vld.
    in_rdy_d  = (state_d == ST_COLLECT);
    out_vld_d = (state_d == ST_DONE);
  end

  // State and handshake registers; reset holds both handshakes low.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q   <= ST_COLLECT;
      q_q       <= Q_INIT;
      qm_q      <= QM_INIT;
      cnt_q     <= {CNT_W{1'b0}};
      err_q     <= 1'b0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      qm_q      <= qm_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign data_in_rdy  = in_rdy_q;
  assign data_out_vld = out_vld_q;
  assign dout         = q_q;
  assign dout_err     = err_q;

endmodule
